ca_gen_sequencer: RTL and testbench
===================================

Name: ca_gen_sequencer

Overview:
Sequences generation of a 1-D elementary cellular automaton into the 60x80 line-buffer image memory.
- Seeds row 0 with a single centre cell.
- Fetches each previous row bit-serially over the memory's 1-bit read port.
- Computes the next generation with a latched 8-bit Wolfram rule and writes it as a full 80-bit line.
- Shares the memory read port with the VGA scanner: the scanner always has priority and the sequencer only reads during blanking.

Parameters:
ROWS, 60, number of image rows (rows 0..ROWS-1)
COLS, 80, cells per row (cols 0..COLS-1)
SEED_COL, 40, column set to 1 in the seed line

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  pulse; begins a new run (ignored while busy=1)
rule  in  8  Wolfram rule number; latched on an accepted start
vga_active  in  1  1 = scanner in visible area and owns the read port
vga_row  in  7  scanner read row
vga_col  in  7  scanner read column
mem_row  out  7  to image read row
mem_col  out  7  to image read column
mem_data  in  1  image read data, valid 1 cycle after address
rowW  out  7  to image write row
dataW  out  80  to image write line; bit c = column c
busy  out  1  high from accepted start until done
done  out  1  1-cycle pulse when row ROWS-1 has committed

Behaviour:
- Reset values: state IDLE, rowW=0, dataW=seed (only bit SEED_COL set), busy=0, done=0, latched rule=0.
- Memory write contract:
  - The image writes rowW/dataW on every clock edge where rowW != mem_row; there is no write enable.
  - rowW/dataW therefore always hold the last committed row and its exact contents, so repeated writes are idempotent.
  - They change only in SEED entry and COMPUTE.
- Read mux: mem_row/mem_col = sequencer fetch address only when state=FETCH and vga_active=0; otherwise = vga_row/vga_col. The mux is combinational.
- IDLE: on start, latch rule, set busy, load rowW=0 and dataW=seed, go to COMMIT with dst=0.
- COMMIT:
  - Waits for a cycle where mem_row != rowW; that edge performs the write.
  - On that edge: if dst=ROWS-1, go to DONE; else src=dst, dst=dst+1, fetch col=0, go to FETCH.
- FETCH:
  - Each cycle with vga_active=0 and col<COLS: present (src, col), set issue-valid, col++.
  - Cycles with vga_active=1 issue nothing.
  - A 1-cycle delayed issue-valid plus issued col captures mem_data into shift register buf[col].
  - A capture is never lost when vga_active rises immediately after an issue.
  - When all COLS captures are complete, go to COMPUTE.
- COMPUTE (1 cycle):
  - next[i] = rule[{buf[(i-1) mod COLS], buf[i], buf[(i+1) mod COLS]}]: left, centre, right, with wrap-around at columns 0 and COLS-1.
  - Set dataW=next, rowW=dst, go to COMMIT.
- DONE (1 cycle): done=1, busy=0, go to IDLE.
- Timing with vga_active held 0 and no commit stall: 81 cycles FETCH, 1 cycle COMPUTE, 1 cycle COMMIT, i.e. 83 cycles per row.
- start during busy is ignored. rule changes during a run have no effect.
- rst mid-run: immediate return to reset values. A partially fetched row is discarded and no partial line is ever driven on dataW.
- Row counters are 7-bit; dst never exceeds ROWS-1.

Decomposition:
- Package ca_pkg holds:
  - state enum {IDLE, COMMIT, FETCH, COMPUTE, DONE}
  - ROWS/COLS defaults
  - seed-line constant function
  - rule-index ordering {L,C,R}
- One sub-module, ca_next_gen: purely combinational COLS-wide rule application with wrap-around (buf, rule -> next).

Test Plan:
- Reset, then vga_row=59 and vga_active=0 held -> rowW=0, dataW has only bit 40 set, busy=0.
- rule=30, start, vga_active=0, vga_row=59 -> row 1 = bits 39,40,41; row 2 = bits 38,39,42; done after 59*83+1 cycles ±1 (excluding seed commit); memory model matches a golden rule-30 array.
- rule=90 with seed edge case SEED_COL=0 -> row 1 = bits 79 and 1 (wrap); row 2 = bits 78 and 2.
- Random vga_active toggling (50%) during rule=110 run -> memory contents identical to the unstalled run; mem_row/mem_col equal vga_row/vga_col every cycle vga_active=1.
- Hold vga_row equal to rowW for 20 cycles in COMMIT -> no state advance or rowW change until vga_row differs; then advance on that edge.
- rst asserted mid-FETCH of row 10, followed by start with rule=30 -> clean run from seed; start pulse during busy -> no effect, single done pulse.

Source files
------------

// File: rtl/ca_pkg.sv
// rtl/ca_pkg.sv - shared types and helpers for the cellular-automaton sequencer
package ca_pkg;

    localparam int ROWS_DEF = 60;
    localparam int COLS_DEF = 80;
    localparam int COLS_MAX = 128;

    typedef enum logic [2:0] {
        IDLE,
        COMMIT,
        FETCH,
        COMPUTE,
        DONE
    } state_t;

    function automatic logic [COLS_MAX-1:0] seed_line(input int col);
        logic [COLS_MAX-1:0] s;
        s = {{(COLS_MAX-1){1'b0}}, 1'b1} << col;
        return s;
    endfunction

    // Wolfram rule bit index: left neighbour is the MSB.
    function automatic logic [2:0] rule_index(input logic l, input logic c, input logic r);
        return {l, c, r};
    endfunction

endpackage

// File: rtl/ca_next_gen.sv
// rtl/ca_next_gen.sv - combinational rule application across one wrapped row
module ca_next_gen
    import ca_pkg::*;
#(
    parameter int COLS = COLS_DEF
) (
    input  logic [COLS-1:0] cells,
    input  logic [7:0]      rule,
    output logic [COLS-1:0] nxt
);

    for (genvar i = 0; i < COLS; i++) begin : g_cell
        localparam int L = (i + COLS - 1) % COLS;
        localparam int R = (i + 1) % COLS;
        assign nxt[i] = rule[rule_index(cells[L], cells[i], cells[R])];
    end

endmodule

// File: rtl/ca_gen_sequencer.sv
// rtl/ca_gen_sequencer.sv - fetches each row bit-serially, applies the rule, commits full lines
module ca_gen_sequencer
    import ca_pkg::*;
#(
    parameter int ROWS     = ROWS_DEF,
    parameter int COLS     = COLS_DEF,
    parameter int SEED_COL = 40
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      rule,
    input  logic            vga_active,
    input  logic [6:0]      vga_row,
    input  logic [6:0]      vga_col,
    output logic [6:0]      mem_row,
    output logic [6:0]      mem_col,
    input  logic            mem_data,
    output logic [6:0]      rowW,
    output logic [COLS-1:0] dataW,
    output logic            busy,
    output logic            done
);

    localparam logic [COLS_MAX-1:0] SEED_FULL = seed_line(SEED_COL);
    localparam logic [COLS-1:0]     SEED      = SEED_FULL[COLS-1:0];
    localparam logic [6:0]          LAST_ROW  = 7'(ROWS - 1);
    localparam logic [6:0]          LAST_COL  = 7'(COLS - 1);
    localparam logic [6:0]          NUM_COLS  = 7'(COLS);

    state_t          state_q, state_d;
    logic [7:0]      rule_q;
    logic [6:0]      dst, src, col, iss_col;
    logic            iss_v;
    logic [COLS-1:0] cells;
    logic [COLS-1:0] nxt;
    logic            issue, commit_fire, accept;

    ca_next_gen #(.COLS(COLS)) u_next_gen (
        .cells (cells),
        .rule  (rule_q),
        .nxt   (nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        done        = 1'b0;
        issue       = 1'b0;
        commit_fire = 1'b0;
        accept      = 1'b0;
        mem_row     = vga_row;
        mem_col     = vga_col;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                busy = 1'b1;
                // The image only writes when its read row differs from rowW.
                if (mem_row != rowW) begin
                    commit_fire = 1'b1;
                    state_d     = (dst == LAST_ROW) ? DONE : FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (!vga_active) begin
                    mem_row = src;
                    mem_col = col;
                    issue   = (col < NUM_COLS);
                end
                if (iss_v && iss_col == LAST_COL) state_d = COMPUTE;
            end
            COMPUTE: begin
                busy    = 1'b1;
                state_d = COMMIT;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rule_q  <= 8'd0;
            rowW    <= 7'd0;
            dataW   <= SEED;
            dst     <= 7'd0;
            src     <= 7'd0;
            col     <= 7'd0;
            iss_v   <= 1'b0;
            iss_col <= 7'd0;
            cells   <= '0;
        end else begin
            // Capture tracks the delayed issue, so a read is kept even if the scanner grabs the port next cycle.
            iss_v <= issue;
            if (issue) begin
                iss_col <= col;
                col     <= col + 7'd1;
            end
            if (iss_v) cells[iss_col] <= mem_data;
            if (accept) begin
                rule_q <= rule;
                rowW   <= 7'd0;
                dataW  <= SEED;
                dst    <= 7'd0;
            end
            if (commit_fire && dst != LAST_ROW) begin
                src <= dst;
                dst <= dst + 7'd1;
                col <= 7'd0;
            end
            if (state_q == COMPUTE) begin
                dataW <= nxt;
                rowW  <= dst;
            end
        end
    end

endmodule

// File: tb/tb_ca_gen_sequencer.sv
// tb/tb_ca_gen_sequencer.sv - directed self-checking bench for ca_gen_sequencer
module tb_ca_gen_sequencer;

    localparam logic [79:0] ONE = 80'd1;

    logic        clk = 1'b0;
    logic        rst, mem_clr;
    logic        start0, start1;
    logic [7:0]  rule0, rule1;
    logic        vga_active;
    logic [6:0]  vga_row, vga_col;

    logic [6:0]  mem_row0, mem_col0, row_w0, mem_row1, mem_col1, row_w1;
    logic [79:0] data_w0, data_w1;
    logic        busy0, done0, busy1, done1, md0, md1;

    logic [79:0] mem0 [0:59];
    logic [79:0] mem1 [0:59];
    logic [79:0] gold [0:59];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ca_gen_sequencer u0 (
        .clk(clk), .rst(rst), .start(start0), .rule(rule0),
        .vga_active(vga_active), .vga_row(vga_row), .vga_col(vga_col),
        .mem_row(mem_row0), .mem_col(mem_col0), .mem_data(md0),
        .rowW(row_w0), .dataW(data_w0), .busy(busy0), .done(done0)
    );

    ca_gen_sequencer #(.SEED_COL(0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .rule(rule1),
        .vga_active(vga_active), .vga_row(vga_row), .vga_col(vga_col),
        .mem_row(mem_row1), .mem_col(mem_col1), .mem_data(md1),
        .rowW(row_w1), .dataW(data_w1), .busy(busy1), .done(done1)
    );

    // Image memory: writes whenever rowW differs from the read row, registered 1-bit read.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int r = 0; r < 60; r++) begin
                mem0[r] <= '0;
                mem1[r] <= '0;
            end
        end else begin
            if (row_w0 != mem_row0 && row_w0 < 7'd60) mem0[row_w0] <= data_w0;
            if (row_w1 != mem_row1 && row_w1 < 7'd60) mem1[row_w1] <= data_w1;
        end
        md0 <= (mem_row0 < 7'd60 && mem_col0 < 7'd80) ? mem0[mem_row0][mem_col0] : 1'b0;
        md1 <= (mem_row1 < 7'd60 && mem_col1 < 7'd80) ? mem1[mem_row1][mem_col1] : 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] gen(input logic [79:0] r, input logic [7:0] rl);
        logic [79:0] n;
        logic [2:0]  idx;
        for (int i = 0; i < 80; i++) begin
            idx  = {r[(i + 79) % 80], r[i], r[(i + 1) % 80]};
            n[i] = rl[idx];
        end
        return n;
    endfunction

    task automatic build_gold(input logic [7:0] rl);
        gold[0] = ONE << 40;
        for (int r = 1; r < 60; r++) gold[r] = gen(gold[r-1], rl);
    endtask

    task automatic chk_gold(input string tag);
        for (int r = 0; r < 60; r++) chk($sformatf("%s_row%0d", tag, r), mem0[r], gold[r]);
    endtask

    task automatic clear_mem();
        mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
    endtask

    initial begin
        int first, dcnt, mux_bad;
        logic seen, moved;

        rst = 1'b1; mem_clr = 1'b1;
        start0 = 1'b0; start1 = 1'b0; rule0 = 8'd0; rule1 = 8'd0;
        vga_active = 1'b0; vga_row = 7'd59; vga_col = 7'd0;
        repeat (3) tick();
        rst = 1'b0; mem_clr = 1'b0;
        tick(); tick();

        chk("reset_rowW", 80'(row_w0), 80'd0);
        chk("reset_dataW", data_w0, ONE << 40);
        chk("reset_busy", 80'(busy0), 80'd0);
        chk("reset_done", 80'(done0), 80'd0);
        chk("reset_dataW_seed0", data_w1, ONE);
        chk("idle_mux_row", 80'(mem_row0), 80'd59);
        chk("reset_seed_written", mem0[0], ONE << 40);

        // Rule 30 on u0 and rule 90 (seed at column 0) on u1, unstalled.
        build_gold(8'd30);
        clear_mem();
        vga_row = 7'd100;
        rule0 = 8'd30; rule1 = 8'd90; start0 = 1'b1; start1 = 1'b1;
        tick();
        start0 = 1'b0; start1 = 1'b0; rule0 = 8'd110;
        first = -1; dcnt = 0;
        for (int k = 0; k < 6000; k++) begin
            if (done0) begin
                dcnt++;
                if (first < 0) first = k;
            end
            if (k == 500) chk("busy_midrun", 80'(busy0), 80'd1);
            if (first >= 0 && k > first + 5) break;
            start0 = (k == 1000);
            tick();
        end
        checks++;
        assert (first >= 4897 && first <= 4899) else begin
            failures++;
            $error("FAIL done_latency observed=%0d expected=4898", first);
        end
        chk("done_pulse_count", 80'(dcnt), 80'd1);
        chk("busy_after_done", 80'(busy0), 80'd0);
        chk("r30_row1", mem0[1], (ONE << 39) | (ONE << 40) | (ONE << 41));
        chk("r30_row2", mem0[2], (ONE << 38) | (ONE << 39) | (ONE << 42));
        chk_gold("r30");
        chk("r90_row1_wrap", mem1[1], (ONE << 79) | (ONE << 1));
        chk("r90_row2_wrap", mem1[2], (ONE << 78) | (ONE << 2));
        chk("u1_busy_after", 80'(busy1), 80'd0);

        // Reset in the middle of fetching row 10.
        clear_mem();
        rule0 = 8'd30; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (row_w0 == 7'd10) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("reach_row10", 80'(seen), 80'd1);
        repeat (40) tick();
        rst = 1'b1;
        tick();
        chk("midrun_rst_dataW", data_w0, ONE << 40);
        rst = 1'b0;
        tick();
        chk("midrun_rst_rowW", 80'(row_w0), 80'd0);
        chk("midrun_rst_busy", 80'(busy0), 80'd0);

        // Clean restart; stall the row-1 commit by holding vga_row on rowW.
        clear_mem();
        rule0 = 8'd30; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (row_w0 == 7'd1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("reach_row1", 80'(seen), 80'd1);
        vga_row = 7'd1;
        moved = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (row_w0 != 7'd1 || mem_row0 != 7'd1) moved = 1'b1;
        end
        chk("stall_no_advance", 80'(moved), 80'd0);
        chk("stall_no_write", mem0[1], 80'd0);
        vga_row = 7'd100;
        tick();
        chk("stall_release_write", mem0[1], (ONE << 39) | (ONE << 40) | (ONE << 41));
        chk("stall_release_fetch_row", 80'(mem_row0), 80'd1);
        chk("stall_release_fetch_col", 80'(mem_col0), 80'd0);
        seen = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            if (done0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("restart_done", 80'(seen), 80'd1);
        tick();
        chk_gold("restart30");

        // Rule 110 with the scanner grabbing the port at random.
        build_gold(8'd110);
        clear_mem();
        rule0 = 8'd110; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        seen = 1'b0; mux_bad = 0;
        for (int k = 0; k < 30000; k++) begin
            vga_active = 1'($urandom_range(0, 1));
            vga_row    = 7'($urandom_range(0, 127));
            vga_col    = 7'($urandom_range(0, 127));
            #1;
            if (vga_active && (mem_row0 != vga_row || mem_col0 != vga_col)) mux_bad++;
            if (done0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        vga_active = 1'b0; vga_row = 7'd100;
        tick();
        chk("r110_done", 80'(seen), 80'd1);
        chk("r110_mux_scanner_priority", 80'(mux_bad), 80'd0);
        chk_gold("r110");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
